// File: rtl/multicycle_control_fsm.sv
// Multicycle main control unit: walks each instruction through fetch, decode,
// execute, memory and write-back, driving datapath selects and write enables.
module multicycle_control_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_source,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ALU_OP,
  output logic [3:0]         ALU_I_OP,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;

  logic       mem_read_c, mem_write_c, i_or_d_c, ir_write_c, pc_write_c;
  logic [1:0] pc_source_c, alu_src_b_c, alu_op_c;
  logic       alu_src_a_c, reg_write_c, reg_dst_c, mem_to_reg_c;
  logic [3:0] alu_i_op_c;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    illegal_d    = illegal_q;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    i_or_d_c     = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_source_c  = 2'b00;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    alu_i_op_c   = 4'b0000;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is classified.
        op_d        = opcode;
        alu_src_b_c = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_R:                              state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_source_c = 2'b01;
        pc_write_c  = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_source_c = 2'b10;
        pc_write_c  = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = 2'b11;
        case (op_q)
          OP_ADDI: alu_i_op_c = 4'b0010;
          OP_ANDI: alu_i_op_c = 4'b0000;
          OP_ORI:  alu_i_op_c = 4'b0001;
          OP_SLTI: alu_i_op_c = 4'b0100;
          default: alu_i_op_c = 4'b0000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset squashes every request in the same cycle, so an in-flight access is dropped.
  assign mem_read   = mem_read_c   & ~rst;
  assign mem_write  = mem_write_c  & ~rst;
  assign i_or_d     = i_or_d_c     & ~rst;
  assign ir_write   = ir_write_c   & ~rst;
  assign pc_write   = pc_write_c   & ~rst;
  assign pc_source  = rst ? 2'b00 : pc_source_c;
  assign alu_src_a  = alu_src_a_c  & ~rst;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_c;
  assign ALU_OP     = rst ? 2'b00 : alu_op_c;
  assign ALU_I_OP   = rst ? 4'b0000 : alu_i_op_c;
  assign reg_write  = reg_write_c  & ~rst;
  assign reg_dst    = reg_dst_c    & ~rst;
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign illegal    = illegal_q    & ~rst;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: an instruction-level model plans each cycle's
// stimulus and expected outputs, and the driver replays the plan against the DUT.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] alu_i_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;
  } out_t;

  localparam int W = $bits(out_t);

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
    OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] alu_i_op, state;

  multicycle_control_fsm #(.OP_W(6), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ALU_OP(alu_op), .ALU_I_OP(alu_i_op), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [8:0]   stim_q[$];  // {rst, mem_ready, zero, opcode}
  logic         m_illegal = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic out_t base(input int st);
    out_t o;
    o = '0;
    o.state = 4'(st);
    o.illegal = m_illegal;
    return o;
  endfunction

  task automatic push(input out_t o, input logic r, input logic rdy, input logic z,
                      input logic [5:0] op);
    exp_q.push_back(o);
    stim_q.push_back({r, rdy, z, op});
  endtask

  function automatic logic rz();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom_range(0, 63));
  endfunction

  // One instruction. fs/ms = stall cycles in fetch / memory phase; zb = zero in BRANCH;
  // kill >= 0 asserts rst in the memory phase with mem_ready = kill[0].
  task automatic do_instr(input logic [5:0] op, input int fs, input int ms,
                          input logic zb, input int kill);
    out_t o;
    logic [1:0] kv;
    kv = 2'(kill);
    for (int i = 0; i < fs; i++) begin
      o = base(0); o.mem_read = 1; o.alu_src_b = 2'b01;
      push(o, 0, 0, rz(), ro());
    end
    o = base(0); o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = 1; o.pc_write = 1;
    push(o, 0, 1, rz(), ro());
    o = base(1); o.alu_src_b = 2'b11;
    push(o, 0, rz(), rz(), op);
    case (op)
      OP_LW, OP_SW: begin
        int st;
        st = (op == OP_LW) ? 3 : 5;
        o = base(2); o.alu_src_a = 1; o.alu_src_b = 2'b10;
        push(o, 0, rz(), rz(), ro());
        for (int i = 0; i < ms; i++) begin
          o = base(st); o.i_or_d = 1;
          if (op == OP_LW) o.mem_read = 1; else o.mem_write = 1;
          push(o, 0, 0, rz(), ro());
        end
        if (kill >= 0) begin
          o = '0; o.state = 4'(st);
          push(o, 1, kv[0], rz(), ro());
          m_illegal = 0;
        end else begin
          o = base(st); o.i_or_d = 1;
          if (op == OP_LW) o.mem_read = 1; else o.mem_write = 1;
          push(o, 0, 1, rz(), ro());
          if (op == OP_LW) begin
            o = base(4); o.reg_write = 1; o.mem_to_reg = 1;
            push(o, 0, rz(), rz(), ro());
          end
        end
      end
      OP_R: begin
        o = base(6); o.alu_src_a = 1; o.alu_op = 2'b10;
        push(o, 0, rz(), rz(), ro());
        o = base(7); o.reg_write = 1; o.reg_dst = 1;
        push(o, 0, rz(), rz(), ro());
      end
      OP_BEQ, OP_BNE: begin
        o = base(8); o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01;
        o.pc_write = (op == OP_BEQ) ? zb : !zb;
        push(o, 0, rz(), zb, ro());
      end
      OP_J: begin
        o = base(9); o.pc_source = 2'b10; o.pc_write = 1;
        push(o, 0, rz(), rz(), ro());
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        o = base(10); o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11;
        o.alu_i_op = (op == OP_ADDI) ? 4'b0010 : (op == OP_ORI) ? 4'b0001 :
                     (op == OP_SLTI) ? 4'b0100 : 4'b0000;
        push(o, 0, rz(), rz(), ro());
        o = base(11); o.reg_write = 1;
        push(o, 0, rz(), rz(), ro());
      end
      default: m_illegal = 1;
    endcase
  endtask

  initial begin
    logic [5:0] legal [10];
    out_t o;
    int cyc;
    legal = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};

    // Reset cycles: outputs forced low even with mem_ready high in FETCH.
    o = '0;
    push(o, 1, 1, 1, ro());
    push(o, 1, 1, 0, ro());

    do_instr(OP_R,    0, 0, 0, -1);
    do_instr(OP_LW,   0, 2, 0, -1);
    do_instr(OP_BEQ,  1, 0, 1, -1);
    do_instr(OP_BEQ,  0, 0, 0, -1);
    do_instr(OP_BNE,  0, 0, 1, -1);
    do_instr(OP_BNE,  2, 0, 0, -1);
    do_instr(OP_ORI,  0, 0, 0, -1);
    do_instr(OP_SLTI, 0, 0, 0, -1);
    do_instr(OP_ADDI, 0, 0, 0, -1);
    do_instr(OP_ANDI, 0, 0, 0, -1);
    do_instr(OP_J,    0, 0, 0, -1);
    do_instr(OP_SW,   0, 1, 0, -1);
    do_instr(6'b111111, 0, 0, 0, -1);
    do_instr(OP_R,    0, 0, 0, -1);
    do_instr(OP_SW,   0, 1, 0, 0);
    do_instr(6'b111111, 1, 0, 0, -1);
    do_instr(OP_LW,   0, 1, 0, 1);
    do_instr(OP_J,    0, 0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 7) == 0) ? ro() : legal[$urandom_range(0, 9)];
      do_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rz(),
               ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1)) : -1);
    end

    @(posedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      logic [8:0] s;
      logic [W-1:0] e;
      out_t eo;
      @(negedge clk);
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      eo = e;
      rst = s[8]; mem_ready = s[7]; zero = s[6]; opcode = s[5:0];
      #2;
      check($sformatf("cyc%0d_st%0d", cyc, eo.state),
            {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
             alu_src_b, alu_op, alu_i_op, reg_write, reg_dst, mem_to_reg, illegal, state},
            e);
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
